dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
Load/store sequencer between the multicycle core and data_memory, with one request outstanding at a time. Converts byte/half/word loads and stores at byte addresses into word-addressed memory accesses. Sub-word stores use read-modify-write, so memory only ever sees full-word writes. Load data is extracted and sign- or zero-extended here, and misaligned or illegal accesses are flagged without touching memory.

Parameters:
CHECK_ALIGN, 1, 1 = misaligned H/W accesses are rejected with rsp_err_o; 0 = low address bits are ignored for H/W (forced to lane 0 / lane 0-1).
(XLEN, DMEM_ADDR come from riscv_pkg; not overridable here.)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  core requests an access
req_ready_o  out  1  controller accepts the request this cycle
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data; used bits are per funct3
req_funct3_i  in  3  RV32I load/store funct3
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  XLEN  extended load result; held until the next load completes
rsp_err_o  out  1  valid with rsp_valid_o: misaligned or illegal funct3
mem_addr_o  out  XLEN  word index = latched addr >> 2, zero-filled
mem_wr_data_o  out  XLEN  merged full word
mem_wr_en_o  out  1  memory write strobe
mem_funct3_o  out  3  constant S_W
mem_rd_data_i  in  XLEN  combinational read data from memory

Behaviour:
- Reset:
  - State IDLE.
  - All latched registers 0, so rsp_rdata_o = 0 and mem_addr_o = 0.
  - rsp_valid_o = 0, rsp_err_o = 0, mem_wr_en_o = 0, req_ready_o = 1.
  - mem_wr_en_o deasserts asynchronously with rst_ni.
- Outputs decoded from state:
  - req_ready_o = (state == IDLE).
  - mem_wr_en_o = (state == WRITE).
  - rsp_valid_o = (state == RESP).
- IDLE: when req_valid_i is high, latch we/addr/wdata/funct3 and choose the next state:
  - Illegal or misaligned request → RESP with error.
    - Load funct3 other than 000/001/010/100/101 is illegal.
    - Store funct3 other than 000/001/010 is illegal.
    - Misaligned: H with addr[0] = 1, or W with addr[1:0] != 0.
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- READ (mem_addr_o valid, mem_rd_data_i sampled at the clock edge):
  - Load: extract the lane, extend, register into rsp_rdata_o, go to RESP.
  - SB/SH: register the merged word, go to WRITE.
- WRITE: one cycle with mem_wr_en_o = 1 and mem_wr_data_o = merged word (SW: wdata unchanged); go to RESP.
- RESP: rsp_valid_o = 1 for exactly one cycle; rsp_err_o = latched error flag; go to IDLE. A new request is accepted the following cycle.
- Latency from the accept edge T:
  - Error: rsp at T+1.
  - Load, SW: rsp at T+2.
  - SB/SH: rsp at T+3.
- Lanes are little-endian.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Merge replaces only the target lane with wdata[7:0] or wdata[15:0]; the other bytes come from the read word.
- Error responses: no memory write occurs and rsp_rdata_o keeps its previous value.
- Stores: rsp_rdata_o is unchanged.
- req_* inputs are ignored outside IDLE. The core must hold them only until the accept handshake.
- Reset mid-operation: the transaction is abandoned, no write is issued after reset asserts, and no rsp_valid_o is produced.

Decomposition:
- riscv_pkg additions:
  - load funct3 constants L_B, L_H, L_W, L_BU, L_HU (stores reuse S_B/S_H/S_W);
  - typedef enum lsu_state_e {IDLE, READ, WRITE, RESP}.
- One natural sub-module: lsu_lane_unit, a combinational block for lane extract/extend and lane merge, shared by READ for both paths.

Test Plan:
- SW 0x11223344 @0x10, then LW @0x10:
  - SW: mem_wr_en_o at T+1 with mem_addr_o = 4; rsp at T+2.
  - LW: rsp_rdata_o = 0x11223344 at T+2.
- SB 0xAA @0x12 over 0x11223344:
  - One READ, then WRITE data 0x11AA3344; rsp at T+3.
  - Then LB @0x12 → 0xFFFFFFAA; LBU @0x12 → 0x000000AA.
- SH 0xBEEF @0x12 over 0x11223344:
  - WRITE data 0xBEEF3344.
  - LH @0x12 → 0xFFFFBEEF; LHU → 0x0000BEEF.
- LW @0x16 and SH @0x11 → rsp_valid_o with rsp_err_o = 1 at T+1, mem_wr_en_o never asserted, rsp_rdata_o unchanged.
- rst_ni pulsed low during READ of an SB → immediate IDLE, req_ready_o = 1, no write pulse, memory word still 0x11223344.
- req_valid_i held high for LW, LW, SW back-to-back → accepts on cycles 0, 3, 6; exactly three rsp_valid_o pulses.

Source files
------------

// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared definitions for the data-memory load/store sequencer.
//   XLEN, DMEM_ADDR : datapath width and memory index width
//   L_* / S_*       : RV32I load/store funct3 encodings
//   lsu_state_e     : sequencer states
package dmem_lsu_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DMEM_ADDR = 10;

  localparam logic [2:0] L_B  = 3'b000;
  localparam logic [2:0] L_H  = 3'b001;
  localparam logic [2:0] L_W  = 3'b010;
  localparam logic [2:0] L_BU = 3'b100;
  localparam logic [2:0] L_HU = 3'b101;

  localparam logic [2:0] S_B  = 3'b000;
  localparam logic [2:0] S_H  = 3'b001;
  localparam logic [2:0] S_W  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_ctrl_lane_unit.sv
// lsu_lane_unit: combinational little-endian lane handling.
//   funct3_i    : access size / signedness
//   offset_i    : byte offset inside the word
//   rd_word_i   : word read from memory
//   wdata_i     : store data (low byte/half used for sub-word stores)
//   load_data_o : extracted and extended load result
//   merged_o    : read word with the target lane replaced by store data
module lsu_lane_unit
  import dmem_lsu_ctrl_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rd_word_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] merged_o
);

  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [XLEN-1:0] byte_word;
  logic [XLEN-1:0] half_word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;

  always_comb begin
    byte_sh   = {offset_i, 3'b000};
    half_sh   = {offset_i[1], 4'b0000};
    byte_word = rd_word_i >> byte_sh;
    half_word = rd_word_i >> half_sh;
    byte_v    = byte_word[7:0];
    half_v    = half_word[15:0];

    load_data_o = rd_word_i;
    mask        = '0;
    ins         = '0;
    merged_o    = wdata_i;

    case (funct3_i[1:0])
      2'b00: begin
        load_data_o = funct3_i[2] ? {{(XLEN-8){1'b0}}, byte_v}
                                  : {{(XLEN-8){byte_v[7]}}, byte_v};
        mask     = XLEN'(8'hFF) << byte_sh;
        ins      = XLEN'(wdata_i[7:0]) << byte_sh;
        merged_o = (rd_word_i & ~mask) | ins;
      end
      2'b01: begin
        load_data_o = funct3_i[2] ? {{(XLEN-16){1'b0}}, half_v}
                                  : {{(XLEN-16){half_v[15]}}, half_v};
        mask     = XLEN'(16'hFFFF) << half_sh;
        ins      = XLEN'(wdata_i[15:0]) << half_sh;
        merged_o = (rd_word_i & ~mask) | ins;
      end
      default: begin
        load_data_o = rd_word_i;
        merged_o    = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: one-outstanding load/store sequencer in front of data_memory.
//   clk_i, rst_ni               : clock, async active-low reset
//   req_valid_i/req_ready_o     : request handshake (accepted in IDLE only)
//   req_we_i, req_addr_i,
//   req_wdata_i, req_funct3_i   : access descriptor (byte address, RV32I funct3)
//   rsp_valid_o, rsp_err_o      : one-cycle completion pulse and error flag
//   rsp_rdata_o                 : extended load data, held until next load
//   mem_addr_o, mem_wr_data_o,
//   mem_wr_en_o, mem_funct3_o   : word-addressed memory side (full-word writes)
//   mem_rd_data_i               : combinational memory read data
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [2:0]      req_funct3_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic            mem_wr_en_o,
  output logic [2:0]      mem_funct3_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  lsu_state_e      state;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  logic            req_legal;
  logic            req_misal;
  logic            req_bad;
  logic [1:0]      lane_off;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  always_comb begin
    if (req_we_i)
      req_legal = req_funct3_i inside {S_B, S_H, S_W};
    else
      req_legal = req_funct3_i inside {L_B, L_H, L_W, L_BU, L_HU};
    req_misal = 1'b0;
    if (CHECK_ALIGN) begin
      case (req_funct3_i[1:0])
        2'b01:   req_misal = req_addr_i[0];
        2'b10:   req_misal = |req_addr_i[1:0];
        default: req_misal = 1'b0;
      endcase
    end
    req_bad = !req_legal || req_misal;
  end

  // Masking the offset for H/W is a no-op when misaligned requests are
  // rejected, and gives the ignore-low-bits behaviour when they are not.
  always_comb begin
    case (funct3_q[1:0])
      2'b01:   lane_off = {addr_q[1], 1'b0};
      2'b10:   lane_off = 2'b00;
      default: lane_off = addr_q[1:0];
    endcase
  end

  lsu_lane_unit u_lane (
    .funct3_i    (funct3_q),
    .offset_i    (lane_off),
    .rd_word_i   (mem_rd_data_i),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // wdata_q doubles as the merged-word register for SB/SH read-modify-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            err_q    <= req_bad;
            if (req_bad)
              state <= RESP;
            else if (!req_we_i)
              state <= READ;
            else if (req_funct3_i == S_W)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          if (we_q) begin
            wdata_q <= merged;
            state   <= WRITE;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state == IDLE);
  assign mem_wr_en_o   = (state == WRITE);
  assign rsp_valid_o   = (state == RESP);
  assign rsp_err_o     = (state == RESP) && err_q;
  assign rsp_rdata_o   = rdata_q;
  assign mem_addr_o    = {2'b00, addr_q[XLEN-1:2]};
  assign mem_wr_data_o = wdata_q;
  assign mem_funct3_o  = S_W;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_f3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_f3;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Simple data_memory stand-in with a backdoor write port for preloading.
  logic [31:0] tbmem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) tbmem[bd_idx] <= bd_val;
    else if (mem_we) tbmem[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata = tbmem[mem_addr[5:0]];

  dmem_lsu_ctrl #(.CHECK_ALIGN(1'b1)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_funct3_i  (req_f3),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .mem_addr_o    (mem_addr),
    .mem_wr_data_o (mem_wdata),
    .mem_wr_en_o   (mem_we),
    .mem_funct3_o  (mem_f3),
    .mem_rd_data_i (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One transaction; reports latency (cycles after the accept edge at which
  // rsp_valid is seen, 0 = never), error, read data and write activity.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, output logic o_err, output int o_lat,
                        output logic [31:0] o_rdata, output int o_nwr,
                        output logic [31:0] o_wdata, output logic [31:0] o_waddr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_f3 = f3;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_f3 = 3'($urandom);
    o_err = 1'b0; o_lat = 0; o_rdata = '0; o_nwr = 0; o_wdata = '0; o_waddr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        o_nwr++; o_wdata = mem_wdata; o_waddr = mem_addr;
      end
      if (rsp_valid) begin
        o_lat = k; o_err = rsp_err; o_rdata = rsp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        err;
    int          lat;
    logic [31:0] rd;
    int          nwr;
    logic [31:0] wword;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wd, logic [2:0] f3,
                              logic err, int lat, logic [31:0] rd, int nwr, logic [31:0] wword);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.f3 = f3; v.err = err;
    v.lat = lat; v.rd = rd; v.nwr = nwr; v.wword = wword;
    return v;
  endfunction

  // Reference model state: byte-addressed memory and last load result.
  logic [7:0]  ref_b [256];
  logic [31:0] m_rdata;

  logic        o_err;
  int          o_lat, o_nwr;
  logic [31:0] o_rdata, o_wdata, o_waddr;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err",    {31'd0, rsp_err},   32'd0);
    chk("rst_wen",    {31'd0, mem_we},    32'd0);
    chk("rst_rdata",  rsp_rdata, 32'd0);
    chk("rst_maddr",  mem_addr,  32'd0);
    chk("mem_f3",     {29'd0, mem_f3}, 32'd2);

    // Directed table
    tbl[0]  = mk(1, 32'h10, 32'h11223344, 3'b010, 0, 2, 32'h0,        1, 32'h11223344);
    tbl[1]  = mk(0, 32'h10, 32'h0,        3'b010, 0, 2, 32'h11223344, 0, 32'h0);
    tbl[2]  = mk(1, 32'h12, 32'h123456AA, 3'b000, 0, 3, 32'h11223344, 1, 32'h11AA3344);
    tbl[3]  = mk(0, 32'h12, 32'h0,        3'b000, 0, 2, 32'hFFFFFFAA, 0, 32'h0);
    tbl[4]  = mk(0, 32'h12, 32'h0,        3'b100, 0, 2, 32'h000000AA, 0, 32'h0);
    tbl[5]  = mk(1, 32'h10, 32'h11223344, 3'b010, 0, 2, 32'h000000AA, 1, 32'h11223344);
    tbl[6]  = mk(1, 32'h12, 32'hCAFEBEEF, 3'b001, 0, 3, 32'h000000AA, 1, 32'hBEEF3344);
    tbl[7]  = mk(0, 32'h12, 32'h0,        3'b001, 0, 2, 32'hFFFFBEEF, 0, 32'h0);
    tbl[8]  = mk(0, 32'h12, 32'h0,        3'b101, 0, 2, 32'h0000BEEF, 0, 32'h0);
    tbl[9]  = mk(0, 32'h16, 32'h0,        3'b010, 1, 1, 32'h0000BEEF, 0, 32'h0);
    tbl[10] = mk(1, 32'h11, 32'h5555,     3'b001, 1, 1, 32'h0000BEEF, 0, 32'h0);
    tbl[11] = mk(0, 32'h10, 32'h0,        3'b011, 1, 1, 32'h0000BEEF, 0, 32'h0);
    tbl[12] = mk(1, 32'h10, 32'h0,        3'b100, 1, 1, 32'h0000BEEF, 0, 32'h0);

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].f3, o_err, o_lat, o_rdata, o_nwr, o_wdata, o_waddr);
      chk($sformatf("t%0d_lat", i),   o_lat, tbl[i].lat);
      chk($sformatf("t%0d_err", i),   {31'd0, o_err}, {31'd0, tbl[i].err});
      chk($sformatf("t%0d_rdata", i), o_rdata, tbl[i].rd);
      chk($sformatf("t%0d_nwr", i),   o_nwr, tbl[i].nwr);
      if (tbl[i].nwr != 0) begin
        chk($sformatf("t%0d_wdata", i), o_wdata, tbl[i].wword);
        chk($sformatf("t%0d_waddr", i), o_waddr, tbl[i].addr >> 2);
      end
    end

    // Back-to-back: req_valid held high for LW, LW, SW
    begin
      int acc [3];
      int nacc, npulse;
      logic rdy;
      nacc = 0; npulse = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_f3 = 3'b010;
      for (int c = 0; c < 12; c++) begin
        if (c > 0) @(negedge clk);
        if (rsp_valid) npulse++;
        rdy = req_ready;
        @(posedge clk);
        if (rdy && req_valid) begin
          if (nacc < 3) acc[nacc] = c;
          nacc++;
          #1;
          if (nacc == 1) begin
            req_addr = 32'h14;
          end else if (nacc == 2) begin
            req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'hDEADBEEF; req_f3 = 3'b010;
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      chk("b2b_nacc", nacc, 3);
      chk("b2b_acc0", acc[0], 0);
      chk("b2b_acc1", acc[1], 3);
      chk("b2b_acc2", acc[2], 6);
      chk("b2b_pulses", npulse, 3);
      chk("b2b_sw", tbmem[6], 32'hDEADBEEF);
    end

    // Reset during the READ of an SB
    begin
      int bad;
      do_txn(1'b1, 32'h10, 32'h11223344, 3'b010, o_err, o_lat, o_rdata, o_nwr, o_wdata, o_waddr);
      chk("pre_rst_lat", o_lat, 2);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h12; req_wdata = 32'hAA; req_f3 = 3'b000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_wen",   {31'd0, mem_we},    32'd0);
      bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (mem_we || rsp_valid) bad++;
      end
      rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (mem_we || rsp_valid) bad++;
      end
      chk("mid_rst_quiet", bad, 0);
      chk("mid_rst_mem",   tbmem[4], 32'h11223344);
      chk("mid_rst_rdata", rsp_rdata, 32'd0);
    end

    // Randomized traffic against the byte-level reference model
    for (int w = 0; w < 64; w++) begin
      logic [31:0] val;
      val = $urandom;
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(w); bd_val = val;
      for (int b = 0; b < 4; b++) ref_b[w*4+b] = val[b*8 +: 8];
    end
    @(negedge clk);
    bd_we = 1'b0;
    m_rdata = '0;

    for (int n = 0; n < 150; n++) begin
      logic        we, legal, mis, e_err;
      logic [2:0]  f3;
      logic [31:0] addr, wd, v, wa, word;
      int          sz, e_lat, e_nwr;
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom_range(0, 255);
      wd   = $urandom;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = 1 << f3[1:0];
      mis   = legal && ((addr % sz) != 0);
      e_err = !legal || mis;
      e_nwr = 0;
      wa    = addr & ~32'd3;
      if (e_err) begin
        e_lat = 1;
      end else if (!we) begin
        e_lat = 2;
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_b[addr+i]) << (8*i));
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
        m_rdata = v;
      end else begin
        e_lat = (sz == 4) ? 2 : 3;
        e_nwr = 1;
        for (int i = 0; i < sz; i++) ref_b[addr+i] = wd[8*i +: 8];
      end
      word = {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
      do_txn(we, addr, wd, f3, o_err, o_lat, o_rdata, o_nwr, o_wdata, o_waddr);
      chk("rnd_lat",   o_lat, e_lat);
      chk("rnd_err",   {31'd0, o_err}, {31'd0, e_err});
      chk("rnd_rdata", o_rdata, m_rdata);
      chk("rnd_nwr",   o_nwr, e_nwr);
      if (e_nwr != 0) begin
        chk("rnd_wdata", o_wdata, word);
        chk("rnd_waddr", o_waddr, addr >> 2);
      end
      chk("rnd_memword", tbmem[wa[7:2]], word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
